// File: rtl/mont_exp_sequencer.sv
// -----------------------------------------------------------------------------
// mont_exp_sequencer
//
// Purpose: computes o_out = i_base ^ i_exponent mod i_modulus by driving an
// external Montgomery multiplier through a right-to-left square-and-multiply
// schedule:
//   r = mont(r2, 1), x = mont(base, r2)
//   for k = 0 .. : if exp[k] r = mont(r, x); if more iterations x = mont(x, x)
//   out = mont(r, 1)
// Exactly one multiplier operation is in flight at any time.
//
// Optional feature macro: MONT_EXP_EARLY_EXIT_EN
//   undefined : always MOD_WIDTH iterations and MOD_WIDTH-1 squares
//               (timing independent of the exponent value)
//   defined   : loop stops after the highest set exponent bit; a zero
//               exponent goes straight from PRE_X to POST
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_valid / i_ready   job request handshake (i_ready only in IDLE)
//   i_base, i_exponent, i_modulus, i_r2
//                       operands; i_r2 = 2^(2*MOD_WIDTH) mod i_modulus,
//                       i_modulus odd
//   o_valid / o_ready   result handshake, o_out held stable while o_valid
//   o_out               modular exponentiation result
//   m_valid / m_ready   request to the Montgomery multiplier
//   m_in                MontgomeryIn flattened as {a, b, modulus}
//                       (a in the most significant MOD_WIDTH bits)
//   mr_valid / mr_ready response from the Montgomery multiplier
//   mr_out              MontgomeryOut result field
// -----------------------------------------------------------------------------
module mont_exp_sequencer #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [MOD_WIDTH-1:0]   i_base,
    input  logic [MOD_WIDTH-1:0]   i_exponent,
    input  logic [MOD_WIDTH-1:0]   i_modulus,
    input  logic [MOD_WIDTH-1:0]   i_r2,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [MOD_WIDTH-1:0]   o_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [3*MOD_WIDTH-1:0] m_in,
    input  logic                   mr_valid,
    output logic                   mr_ready,
    input  logic [MOD_WIDTH-1:0]   mr_out
);

    localparam int KW = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
    localparam logic [KW-1:0]        K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0]        K_ONE  = KW'(1);
    localparam logic [KW-1:0]        K_LAST = KW'(MOD_WIDTH - 1);
    localparam logic [MOD_WIDTH-1:0] W_ZERO = {MOD_WIDTH{1'b0}};
    localparam logic [MOD_WIDTH-1:0] W_ONE  = MOD_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_R    = 3'd1,
        PRE_X    = 3'd2,
        LOOP_MUL = 3'd3,
        LOOP_SQR = 3'd4,
        POST     = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                 state_r;
    logic [KW-1:0]          k_r;
    logic [MOD_WIDTH-1:0]   base_r;
    logic [MOD_WIDTH-1:0]   exp_r;
    logic [MOD_WIDTH-1:0]   mod_r;
    logic [MOD_WIDTH-1:0]   r2_r;
    logic [MOD_WIDTH-1:0]   r_r;
    logic [MOD_WIDTH-1:0]   x_r;
    logic [MOD_WIDTH-1:0]   m_a_r;
    logic [MOD_WIDTH-1:0]   m_b_r;
    logic [MOD_WIDTH-1:0]   o_out_r;
    logic                   m_valid_r;
    logic                   mr_ready_r;
    logic                   o_valid_r;
    logic                   i_ready_r;

    // Routing decided when the current multiplier response arrives.
    logic [KW-1:0]          kk_s;
    logic                   last_s;
    logic                   enter_s;
    logic                   decide_s;
    state_t                 nxt_state_s;
    logic [MOD_WIDTH-1:0]   nxt_a_s;
    logic [MOD_WIDTH-1:0]   nxt_b_s;
    logic [MOD_WIDTH-1:0]   nxt_r_s;
    logic [MOD_WIDTH-1:0]   nxt_x_s;

    assign i_ready  = i_ready_r;
    assign o_valid  = o_valid_r;
    assign o_out    = o_out_r;
    assign m_valid  = m_valid_r;
    assign mr_ready = mr_ready_r;
    assign m_in     = {m_a_r, m_b_r, mod_r};

    // Exponent bit index the next loop decision refers to.
    always_comb begin
        case (state_r)
            PRE_X:    kk_s = K_ZERO;
            LOOP_SQR: kk_s = k_r + K_ONE;   // k_r < K_LAST here, never wraps
            default:  kk_s = k_r;
        endcase
    end

    // Whether iteration kk_s is the final one of the loop.
    always_comb begin
`ifdef MONT_EXP_EARLY_EXIT_EN
        last_s = (kk_s == K_LAST) || (((exp_r >> kk_s) >> 1'b1) == W_ZERO);
`else
        last_s = (kk_s == K_LAST);
`endif
    end

    // Next state and next multiplier operands once the response is captured.
    always_comb begin
        nxt_state_s = state_r;
        nxt_a_s     = m_a_r;
        nxt_b_s     = m_b_r;
        nxt_r_s     = r_r;
        nxt_x_s     = x_r;
        enter_s     = 1'b0;
        decide_s    = 1'b0;
        case (state_r)
            PRE_R: begin
                nxt_r_s     = mr_out;
                nxt_state_s = PRE_X;
                nxt_a_s     = base_r;
                nxt_b_s     = r2_r;
            end
            PRE_X: begin
                nxt_x_s = mr_out;
                enter_s = 1'b1;
            end
            LOOP_MUL: begin
                nxt_r_s  = mr_out;
                decide_s = 1'b1;
            end
            LOOP_SQR: begin
                nxt_x_s = mr_out;
                enter_s = 1'b1;
            end
            POST: begin
                nxt_state_s = DONE;
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase

        // Entering iteration kk_s: multiply only when its exponent bit is set,
        // otherwise fall through to the square-or-finish decision.
        if (enter_s && exp_r[kk_s]) begin
            nxt_state_s = LOOP_MUL;
            nxt_a_s     = nxt_r_s;
            nxt_b_s     = nxt_x_s;
        end else if (enter_s || decide_s) begin
            if (last_s) begin
                nxt_state_s = POST;
                nxt_a_s     = nxt_r_s;
                nxt_b_s     = W_ONE;
            end else begin
                nxt_state_s = LOOP_SQR;
                nxt_a_s     = nxt_x_s;
                nxt_b_s     = nxt_x_s;
            end
        end else begin
            // PRE_R and POST targets were set in the case above.
        end
    end

    // Sequencer state machine with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            k_r        <= K_ZERO;
            base_r     <= W_ZERO;
            exp_r      <= W_ZERO;
            mod_r      <= W_ZERO;
            r2_r       <= W_ZERO;
            r_r        <= W_ZERO;
            x_r        <= W_ZERO;
            m_a_r      <= W_ZERO;
            m_b_r      <= W_ZERO;
            o_out_r    <= W_ZERO;
            m_valid_r  <= 1'b0;
            mr_ready_r <= 1'b0;
            o_valid_r  <= 1'b0;
            i_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid && i_ready_r) begin
                        base_r    <= i_base;
                        exp_r     <= i_exponent;
                        mod_r     <= i_modulus;
                        r2_r      <= i_r2;
                        r_r       <= W_ZERO;
                        x_r       <= W_ZERO;
                        k_r       <= K_ZERO;
                        m_a_r     <= i_r2;
                        m_b_r     <= W_ONE;
                        m_valid_r <= 1'b1;
                        i_ready_r <= 1'b0;
                        state_r   <= PRE_R;
                    end else begin
                        i_ready_r <= 1'b1;
                    end
                end
                PRE_R, PRE_X, LOOP_MUL, LOOP_SQR, POST: begin
                    // Request phase, then response phase; mr_valid is only
                    // looked at while mr_ready is high.
                    if (m_valid_r) begin
                        if (m_ready) begin
                            m_valid_r  <= 1'b0;
                            mr_ready_r <= 1'b1;
                        end else begin
                            m_valid_r  <= 1'b1;
                        end
                    end else if (mr_ready_r && mr_valid) begin
                        mr_ready_r <= 1'b0;
                        state_r    <= nxt_state_s;
                        r_r        <= nxt_r_s;
                        x_r        <= nxt_x_s;
                        k_r        <= kk_s;
                        m_a_r      <= nxt_a_s;
                        m_b_r      <= nxt_b_s;
                        if (nxt_state_s == DONE) begin
                            o_out_r   <= mr_out;
                            o_valid_r <= 1'b1;
                        end else begin
                            m_valid_r <= 1'b1;
                        end
                    end else begin
                        mr_ready_r <= mr_ready_r;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_r <= 1'b0;
                        i_ready_r <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        o_valid_r <= 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean idle.
                    state_r    <= IDLE;
                    m_valid_r  <= 1'b0;
                    mr_ready_r <= 1'b0;
                    o_valid_r  <= 1'b0;
                    i_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mont_exp_sequencer
//
// Bench for mont_exp_sequencer with MOD_WIDTH = 8. A behavioural Montgomery
// multiplier (mont(a,b) = a*b*R^-1 mod m, R = 256) answers the DUT with
// optional random stalls; results are compared with a plain modular power and
// the multiplier operation count with the count implied by the exponent bits.
// -----------------------------------------------------------------------------
module tb_mont_exp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  i_base;
    logic [7:0]  i_exponent;
    logic [7:0]  i_modulus;
    logic [7:0]  i_r2;
    logic        o_valid;
    logic        o_ready;
    logic [7:0]  o_out;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_in;
    logic        mr_valid;
    logic        mr_ready;
    logic [7:0]  mr_out;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          op_count = 0;
    logic        stall_en = 1'b0;
    logic [7:0]  cur_mod = 8'd13;

    mont_exp_sequencer #(.MOD_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_base(i_base), .i_exponent(i_exponent), .i_modulus(i_modulus), .i_r2(i_r2),
        .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_in(m_in),
        .mr_valid(mr_valid), .mr_ready(mr_ready), .mr_out(mr_out)
    );

    always #5 clk = ~clk;

    // a * b * 256^-1 mod m, with the inverse found by search
    function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        int unsigned mm;
        int unsigned rinv;
        int unsigned prod;
        mm = {24'd0, m};
        rinv = 0;
        for (int unsigned i = 0; i < mm; i++) if (((i * 256) % mm) == 1) rinv = i;
        prod = ({24'd0, a} * {24'd0, b}) % mm;
        return 8'((prod * rinv) % mm);
    endfunction

    // b^e mod m by repeated multiplication
    function automatic logic [7:0] modpow(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
        int unsigned mm;
        int unsigned acc;
        mm = {24'd0, m};
        acc = 1 % mm;
        for (int i = 0; i < int'(e); i++) acc = (acc * {24'd0, b}) % mm;
        return 8'(acc);
    endfunction

    // Multiplier operations the schedule needs for exponent e (8-bit width).
    function automatic int exp_ops(input logic [7:0] e);
        int pc;
        int msb;
        pc = 0;
        msb = -1;
        for (int i = 0; i < 8; i++) if (e[i]) begin pc++; msb = i; end
`ifdef MONT_EXP_EARLY_EXIT_EN
        if (e == 8'd0) return 3;
        return 2 + pc + msb + 1;
`else
        return 2 + pc + 7 + 1;
`endif
    endfunction

    // Behavioural Montgomery multiplier driven on the falling edge.
    initial begin : mult_stub
        int          st;
        int          dly;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        wait_prev;
        logic        mrr_seen;
        logic [23:0] prev_min;
        st = 0; dly = 0; ra = 8'd0; rb = 8'd0;
        wait_prev = 1'b0; mrr_seen = 1'b0; prev_min = 24'd0;
        m_ready = 1'b0; mr_valid = 1'b0; mr_out = 8'd0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                m_ready = 1'b0; mr_valid = 1'b0; st = 0; wait_prev = 1'b0;
            end else begin
                if (wait_prev) begin
                    tests_run++;
                    if (m_valid !== 1'b1 || m_in !== prev_min) begin
                        tests_failed++;
                        $display("FAIL m_in_stable: got m_valid=%b m_in=%h, want m_valid=1 m_in=%h", m_valid, m_in, prev_min);
                    end
                end
                wait_prev = 1'b0;
                case (st)
                    0: begin
                        mr_valid = 1'b0;
                        if (m_ready) begin
                            m_ready = 1'b0;
                            op_count++;
                            st = 1;
                            dly = stall_en ? int'($urandom_range(0, 3)) : 0;
                        end else if (m_valid === 1'b1) begin
                            ra = m_in[23:16];
                            rb = m_in[15:8];
                            tests_run++;
                            if (m_in[7:0] !== cur_mod) begin
                                tests_failed++;
                                $display("FAIL m_in_modulus: got %0d, want %0d", m_in[7:0], cur_mod);
                            end
                            m_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
                            if (!m_ready) begin wait_prev = 1'b1; prev_min = m_in; end
                        end else if (stall_en && mr_ready === 1'b0 && $urandom_range(0, 3) == 0) begin
                            mr_valid = 1'b1;
                            mr_out = 8'($urandom);
                        end
                    end
                    1: begin
                        tests_run++;
                        if (m_valid !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL one_outstanding: got m_valid=%b, want 0", m_valid);
                        end
                        if (dly == 0) begin
                            mr_valid = 1'b1;
                            mr_out = mont(ra, rb, cur_mod);
                            mrr_seen = mr_ready;
                            st = 2;
                        end else begin
                            dly--;
                        end
                    end
                    default: begin
                        if (mrr_seen) begin mr_valid = 1'b0; st = 0; end
                        else mrr_seen = mr_ready;
                    end
                endcase
            end
        end
    end

    // One complete job; hold = cycles o_ready stays low after o_valid,
    // junk = cycles of stray i_valid while the job runs.
    task automatic run_job(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                           input int hold, input int junk, output logic [7:0] res, output int ops);
        int cyc;
        @(negedge clk);
        op_count = 0;
        cur_mod = m;
        tests_run++;
        if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL i_ready_idle: got %b, want 1", i_ready); end
        i_base = b; i_exponent = e; i_modulus = m;
        i_r2 = 8'(65536 % int'({24'd0, m}));
        o_ready = (hold == 0) ? 1'b1 : 1'b0;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        tests_run++;
        if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL i_ready_busy: got %b, want 0", i_ready); end
        cyc = 0;
        while (o_valid !== 1'b1 && cyc < 4000) begin
            if (cyc < junk) begin
                i_valid = 1'b1; i_base = 8'($urandom); i_exponent = 8'($urandom);
                i_modulus = 8'($urandom); i_r2 = 8'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc <= junk) begin
                tests_run++;
                if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL i_ready_junk: got %b, want 0", i_ready); end
            end
        end
        i_valid = 1'b0;
        res = o_out;
        ops = op_count;
        tests_run++;
        if (o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL o_valid_timeout: got o_valid=%b after %0d cycles, want 1", o_valid, cyc);
            rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; @(negedge clk);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            tests_run++;
            if (o_valid !== 1'b1 || o_out !== res || i_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL output_hold: got o_valid=%b o_out=%0d i_ready=%b, want 1 %0d 0", o_valid, o_out, i_ready, res);
            end
        end
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        tests_run++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL return_idle: got i_ready=%b o_valid=%b, want 1 0", i_ready, o_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_valid !== 1'b0 || m_valid !== 1'b0 || mr_ready !== 1'b0 || o_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got o_valid=%b m_valid=%b mr_ready=%b o_out=%0d, want 0 0 0 0", o_valid, m_valid, mr_ready, o_out);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got i_ready=%b o_valid=%b m_valid=%b, want 1 0 0", i_ready, o_valid, m_valid);
        end
    endtask

    task automatic test_known;
        logic [7:0] res;
        int         ops;
        int         want_ops;
        run_job(8'd3, 8'd5, 8'd13, 0, 0, res, ops);
`ifdef MONT_EXP_EARLY_EXIT_EN
        want_ops = 7;
`else
        want_ops = 12;
`endif
        tests_run++;
        if (res !== 8'd9) begin tests_failed++; $display("FAIL known_3_5: got %0d, want 9", res); end
        tests_run++;
        if (ops != want_ops) begin tests_failed++; $display("FAIL ops_3_5: got %0d, want %0d", ops, want_ops); end
        run_job(8'd4, 8'd13, 8'd13, 0, 0, res, ops);
        tests_run++;
        if (res !== 8'd4) begin tests_failed++; $display("FAIL known_4_13: got %0d, want 4", res); end
        run_job(8'd7, 8'd0, 8'd13, 0, 0, res, ops);
`ifdef MONT_EXP_EARLY_EXIT_EN
        want_ops = 3;
`else
        want_ops = 10;
`endif
        tests_run++;
        if (res !== 8'd1) begin tests_failed++; $display("FAIL known_7_0: got %0d, want 1", res); end
        tests_run++;
        if (ops != want_ops) begin tests_failed++; $display("FAIL ops_7_0: got %0d, want %0d", ops, want_ops); end
    endtask

    task automatic test_output_hold;
        logic [7:0] res;
        int         ops;
        run_job(8'd3, 8'd5, 8'd13, 20, 0, res, ops);
        tests_run++;
        if (res !== 8'd9) begin tests_failed++; $display("FAIL hold_result: got %0d, want 9", res); end
    endtask

    task automatic test_ignore_ivalid;
        logic [7:0] res;
        int         ops;
        run_job(8'd4, 8'd13, 8'd13, 0, 6, res, ops);
        tests_run++;
        if (res !== 8'd4) begin tests_failed++; $display("FAIL ignore_ivalid_result: got %0d, want 4", res); end
        tests_run++;
        if (ops != exp_ops(8'd13)) begin tests_failed++; $display("FAIL ignore_ivalid_ops: got %0d, want %0d", ops, exp_ops(8'd13)); end
    endtask

    task automatic test_random(input int n);
        logic [7:0] b;
        logic [7:0] e;
        logic [7:0] m;
        logic [7:0] res;
        int         ops;
        for (int j = 0; j < n; j++) begin
            b = 8'($urandom);
            e = 8'($urandom);
            m = 8'($urandom_range(1, 127) * 2 + 1);
            run_job(b, e, m, 0, 0, res, ops);
            tests_run++;
            if (res !== modpow(b, e, m)) begin
                tests_failed++;
                $display("FAIL random_result: %0d^%0d mod %0d got %0d, want %0d", b, e, m, res, modpow(b, e, m));
            end
            tests_run++;
            if (ops != exp_ops(e)) begin
                tests_failed++;
                $display("FAIL random_ops: exp %0d got %0d, want %0d", e, ops, exp_ops(e));
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] res;
        int         ops;
        stall_en = 1'b1;
        run_job(8'd3, 8'd5, 8'd13, 0, 0, res, ops);
        tests_run++;
        if (res !== 8'd9) begin tests_failed++; $display("FAIL stall_3_5: got %0d, want 9", res); end
        test_random(8);
        stall_en = 1'b0;
    endtask

    task automatic test_mid_reset;
        int         cyc;
        logic [7:0] res;
        int         ops;
        stall_en = 1'b0;
        @(negedge clk);
        op_count = 0;
        cur_mod = 8'd13;
        i_base = 8'd3; i_exponent = 8'd5; i_modulus = 8'd13; i_r2 = 8'd3;
        o_ready = 1'b1;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        cyc = 0;
        // fourth operation of (3,5) is the first square
        while (!(op_count == 3 && m_valid === 1'b1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (!(op_count == 3 && m_valid === 1'b1)) begin
            tests_failed++;
            $display("FAIL reach_loop_sqr: got op_count=%0d m_valid=%b, want 3 1", op_count, m_valid);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_abort: got m_valid=%b o_valid=%b, want 0 0", m_valid, o_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        o_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0 || m_valid !== 1'b0 || mr_ready !== 1'b0 || o_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_idle: got i_ready=%b o_valid=%b m_valid=%b mr_ready=%b o_out=%0d, want 1 0 0 0 0",
                     i_ready, o_valid, m_valid, mr_ready, o_out);
        end
        run_job(8'd3, 8'd5, 8'd13, 0, 0, res, ops);
        tests_run++;
        if (res !== 8'd9) begin tests_failed++; $display("FAIL after_reset_3_5: got %0d, want 9", res); end
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_base = 8'd0; i_exponent = 8'd0; i_modulus = 8'd13; i_r2 = 8'd3;
        o_ready = 1'b0;
        test_reset;
        test_known;
        test_output_hold;
        test_ignore_ivalid;
        test_random(12);
        test_stall;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mont_exp_sequencer.md
MONT_EXP_SEQUENCER -- requirements
Module: mont_exp_sequencer

Interface
REQ-001 The block SHALL have parameter MOD_WIDTH, default 256, giving the width of modulus, base, exponent and result.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous, active-high reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit, and i_ready, output, 1 bit, forming the job request handshake.
REQ-005 The block SHALL have ports i_base, i_exponent, i_modulus and i_r2, each an input of MOD_WIDTH bits, where i_r2 = 2^(2*MOD_WIDTH) mod i_modulus and i_modulus is odd.
REQ-006 The block SHALL have port o_valid, output, 1 bit, and o_ready, input, 1 bit, forming the result handshake.
REQ-007 The block SHALL have port o_out, output, MOD_WIDTH bits, carrying i_base^i_exponent mod i_modulus.
REQ-008 The block SHALL have ports m_valid, output, 1 bit, m_ready, input, 1 bit, and m_in, output of type MontgomeryIn (fields a, b, modulus), forming the request to the Montgomery multiplier.
REQ-009 The block SHALL have ports mr_valid, input, 1 bit, mr_ready, output, 1 bit, and mr_out, input of type MontgomeryOut, forming the response from the Montgomery multiplier.

Function
REQ-010 A job SHALL be accepted only in IDLE, on a cycle where i_valid && i_ready; all four operands SHALL be registered at acceptance.
REQ-011 The state machine SHALL have states IDLE -> PRE_R -> PRE_X -> LOOP_MUL/LOOP_SQR -> POST -> DONE -> IDLE.
REQ-012 Every non-IDLE/DONE state SHALL issue exactly one multiplier operation: raise m_valid with a stable m_in until m_ready, then deassert m_valid, hold mr_ready=1 until mr_valid, capture mr_out, and then advance.
REQ-013 At most one multiplier operation SHALL be outstanding at a time.
REQ-014 PRE_R SHALL compute r = mont(r2, 1) and PRE_X SHALL compute x = mont(base, r2).
REQ-015 The loop SHALL scan the exponent LSB first with bit index k: when bit k is 1, LOOP_MUL SHALL compute r = mont(r, x); LOOP_SQR SHALL compute x = mont(x, x) only when another iteration follows.
REQ-016 LOOP_MUL SHALL be skipped when bit k is 0.
REQ-017 POST SHALL compute o_out = mont(r, 1) and register it.
REQ-018 In DONE, o_valid SHALL be 1 and o_out SHALL be held stable until o_ready; the handshake SHALL return the block to IDLE.
REQ-019 i_ready SHALL be 1 only in IDLE.
REQ-020 The k counter SHALL be $clog2(MOD_WIDTH) bits wide and SHALL never wrap; the iteration with k = MOD_WIDTH-1 SHALL be the last.
REQ-021 m_in.modulus SHALL always equal the registered modulus.
REQ-022 i_valid asserted outside IDLE SHALL be ignored and SHALL not disturb the running job.
REQ-023 An mr_valid received while mr_ready = 0 SHALL be ignored.

Reset
REQ-024 While rst is high: state SHALL be IDLE, i_ready=1 (once rst is released), o_valid=0, m_valid=0, mr_ready=0, o_out=0, and all operand/working registers 0.
REQ-025 A reset asserted mid-job SHALL abort the job immediately, with no output produced; the attached multiplier is reset by the same rst.

Configuration
REQ-026 With MONT_EXP_EARLY_EXIT_EN defined, the loop SHALL terminate after the highest set exponent bit, skipping the remaining squares; exponent 0 SHALL go PRE_X -> POST directly.
REQ-027 Without MONT_EXP_EARLY_EXIT_EN, exactly MOD_WIDTH iterations and MOD_WIDTH-1 squares SHALL always run, giving data-independent timing.

Verification (MOD_WIDTH=8, modulus 13, r2 3)
REQ-028 The bench SHALL apply base 3, exponent 5 -> o_out 9; multiplier operations SHALL be 12 without the macro and 7 with it.
REQ-029 The bench SHALL apply base 4, exponent 13 -> o_out 4.
REQ-030 The bench SHALL apply base 7, exponent 0 -> o_out 1; multiplier operations SHALL be 10 without the macro and 3 with it.
REQ-031 The bench SHALL hold o_ready=0 for 20 cycles after o_valid -> o_out stable, i_ready=0, and IDLE reached on the cycle after o_ready.
REQ-032 The bench SHALL randomly stall m_ready and mr_valid and check that m_in is stable while m_valid && !m_ready and that results are unchanged.
REQ-033 The bench SHALL assert rst in LOOP_SQR -> m_valid=0 and o_valid=0 in the same cycle; a following job (3, 5) SHALL return 9.
